ssp_ahb_regs: RTL and testbench
===============================

Name: ssp_ahb_regs

Overview:
AHB-Lite slave register block on HCLK holding the SSP/CRC transfer configuration: data address, CRC address, length select and bit-order select. It sits directly upstream of the register synchroniser stage. It drives the configuration fields plus a level `req`, and holds them stable until the synchroniser returns its one-cycle `ack` pulse. It also enforces a guard interval so the synchroniser's internal chain drains before the next request.

Parameters:
DATA_WIDTH, 16, width of HWDATA/HRDATA used for register access (minimum 16)
ADDR_WIDTH, 6, width of the DADR/CADR fields forwarded downstream
GUARD_CYCLES, 6, idle cycles after `req` falls before a new request may start (1..255)
TIMEOUT_CYCLES, 255, maximum cycles `req` stays high waiting for `ack` (1..65535)

Ports:
HCLK  in  1  system clock, all logic on its rising edge
HRESET  in  1  synchronous active-high reset
HSEL  in  1  slave select
HADDR  in  8  byte address, bits [4:2] decoded
HTRANS  in  2  AHB transfer type; bit1=1 means NONSEQ/SEQ
HWRITE  in  1  1=write
HREADY  in  1  bus ready (address phase qualifier)
HWDATA  in  DATA_WIDTH  write data (data phase)
HRDATA  out  DATA_WIDTH  read data (data phase)
HREADYOUT  out  1  constant 1 (zero wait states)
HRESP  out  1  constant 0 (OKAY)
ack  in  1  one-cycle pulse from the synchroniser: fields captured
req  out  1  request level to the synchroniser
DADR  out  ADDR_WIDTH  data address field
CADR  out  ADDR_WIDTH  CRC address field
DLEN  out  1  length select
DBIT  out  1  bit-order select
irq  out  1  level interrupt = (DONE & IE) | ERR_TO | ERR_WB

Behaviour:
- Reset: req=0; DADR=CADR=0; DLEN=DBIT=0; IE=0; all status bits 0; FSM=IDLE; counters=0; HRDATA=0.
- Address phase is accepted when HSEL & HTRANS[1] & HREADY. HADDR[4:2] and HWRITE are registered; the data phase is the next cycle.
- Write takes effect at the end of its data phase.
- Read: HRDATA is driven from the registered address during the data phase, unused bits 0.
- Register map (word offsets):
  - 0x00 DADR [ADDR_WIDTH-1:0] RW
  - 0x04 CADR RW
  - 0x08 CFG: bit0 DLEN, bit1 DBIT, bit2 IE; RW
  - 0x0C CTRL: bit0 START, write-1 pulse, reads 0
  - 0x10 STATUS: bit0 BUSY (RO), bit1 DONE, bit2 ERR_TO, bit3 ERR_WB; bits 1-3 sticky, write-1-to-clear
  - Other offsets read 0; writes to them are ignored.
- FSM (BUSY = state != IDLE):
  - IDLE: START write -> REQ, req<=1 in the same cycle START is committed, timeout counter<=0.
  - REQ: if ack -> GUARD, req<=0, DONE<=1. Else if counter==TIMEOUT_CYCLES-1 -> GUARD, req<=0, ERR_TO<=1. Else counter+1.
  - GUARD: counter counts 0..GUARD_CYCLES-1, then -> IDLE.
- Latency: START data phase at cycle N -> req high from N+1.
  - ack at cycle M -> req low from M+1, DONE visible at M+1.
  - First new START is accepted at M+1+GUARD_CYCLES.
- While BUSY:
  - Writes to DADR/CADR/CFG are dropped and set ERR_WB.
  - START writes are dropped and set ERR_WB.
  - STATUS writes are honoured.
- ack outside REQ is ignored.
- A same-cycle W1C of DONE and the DONE set: the set wins.
- Reset mid-operation returns everything to reset values at the next edge; req drops immediately.
- Counters saturate; they never wrap.

Test Plan:
- Write DADR=0x15, CADR=0x2A, CFG=0x3, then START; ack pulses 3 cycles after req rises -> req high exactly 4 cycles, DADR/CADR/DLEN/DBIT=0x15/0x2A/1/1 stable throughout, STATUS=0x2 after ack.
- Write DADR=0x07 while BUSY -> DADR stays 0x15, STATUS.ERR_WB=1, irq=1. Write STATUS=0x8 -> ERR_WB=0.
- START issued back-to-back right after ack -> ignored with ERR_WB during GUARD. START at ack+1+GUARD_CYCLES -> req rises.
- With TIMEOUT_CYCLES=8 and no ack -> req high 8 cycles then low, ERR_TO=1, DONE=0.
- Assert HRESET while in REQ -> req=0 and all registers 0 next cycle. A following read of 0x00 returns 0.
- Reads of 0x0C and 0x14 return 0. Stray ack in IDLE leaves STATUS unchanged. HREADYOUT=1 and HRESP=0 at all times.

Source files
------------

// File: rtl/ssp_ahb_regs.sv
`default_nettype none
// ============================================================================
//  Module      : ssp_ahb_regs
//  Description : AHB-Lite register block holding the SSP/CRC transfer
//                configuration. Presents the fields plus a level req to the
//                register synchroniser and holds them until its ack pulse,
//                then enforces a guard interval before the next request.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssp_ahb_regs #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 6,
    parameter int GUARD_CYCLES   = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [7:0]            HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    input  logic                  ack,
    output logic                  req,
    output logic [ADDR_WIDTH-1:0] DADR,
    output logic [ADDR_WIDTH-1:0] CADR,
    output logic                  DLEN,
    output logic                  DBIT,
    output logic                  irq
);

    localparam logic [2:0]  c_OFF_DADR   = 3'd0;
    localparam logic [2:0]  c_OFF_CADR   = 3'd1;
    localparam logic [2:0]  c_OFF_CFG    = 3'd2;
    localparam logic [2:0]  c_OFF_CTRL   = 3'd3;
    localparam logic [2:0]  c_OFF_STATUS = 3'd4;
    localparam logic [15:0] c_TO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] c_GUARD_LAST = 16'(GUARD_CYCLES - 1);
    localparam logic [15:0] c_CNT_MAX    = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    // Bus data-phase registers
    logic                  r_dp_valid;
    logic [2:0]            r_dp_addr;
    logic                  r_dp_write;

    // Configuration and status
    logic [ADDR_WIDTH-1:0] r_dadr;
    logic [ADDR_WIDTH-1:0] r_cadr;
    logic                  r_dlen;
    logic                  r_dbit;
    logic                  r_ie;
    logic                  r_done;
    logic                  r_err_to;
    logic                  r_err_wb;

    // Handshake FSM
    state_t                r_state;
    logic [15:0]           r_cnt;
    logic                  r_req;

    logic                  w_busy;
    logic                  w_wr;
    logic                  w_wr_cfgregs;
    logic                  w_wr_status;
    logic                  w_start;
    logic                  w_ack_done;
    logic                  w_timeout;
    logic                  w_set_wb;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused;

    assign w_busy       = (r_state != S_IDLE);
    assign w_wr         = r_dp_valid & r_dp_write;
    assign w_wr_cfgregs = w_wr & ((r_dp_addr == c_OFF_DADR) |
                                  (r_dp_addr == c_OFF_CADR) |
                                  (r_dp_addr == c_OFF_CFG));
    assign w_wr_status  = w_wr & (r_dp_addr == c_OFF_STATUS);
    assign w_start      = w_wr & (r_dp_addr == c_OFF_CTRL) & HWDATA[0];
    assign w_ack_done   = (r_state == S_REQ) & ack;
    assign w_timeout    = (r_state == S_REQ) & ~ack & (r_cnt == c_TO_LAST);
    assign w_set_wb     = w_busy & (w_wr_cfgregs | w_start);

    // Only HADDR[4:2], HTRANS[1] and low HWDATA bits carry meaning here
    assign w_unused     = ^{HWDATA, HADDR[7:5], HADDR[1:0], HTRANS[0]};

    // Register the address phase so the access completes in the next cycle
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_addr  <= 3'd0;
            r_dp_write <= 1'b0;
        end else begin
            r_dp_valid <= HSEL & HTRANS[1] & HREADY;
            r_dp_addr  <= HADDR[4:2];
            r_dp_write <= HWRITE;
        end
    end

    // Configuration fields are frozen while a request is in flight
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dadr <= '0;
            r_cadr <= '0;
            r_dlen <= 1'b0;
            r_dbit <= 1'b0;
            r_ie   <= 1'b0;
        end else if (w_wr && !w_busy) begin
            if (r_dp_addr == c_OFF_DADR) r_dadr <= HWDATA[ADDR_WIDTH-1:0];
            if (r_dp_addr == c_OFF_CADR) r_cadr <= HWDATA[ADDR_WIDTH-1:0];
            if (r_dp_addr == c_OFF_CFG) begin
                r_dlen <= HWDATA[0];
                r_dbit <= HWDATA[1];
                r_ie   <= HWDATA[2];
            end
        end
    end

    // Sticky status: write-1 clears, a same-cycle hardware set takes priority
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_done   <= 1'b0;
            r_err_to <= 1'b0;
            r_err_wb <= 1'b0;
        end else begin
            r_done   <= w_ack_done | (r_done   & ~(w_wr_status & HWDATA[1]));
            r_err_to <= w_timeout  | (r_err_to & ~(w_wr_status & HWDATA[2]));
            r_err_wb <= w_set_wb   | (r_err_wb & ~(w_wr_status & HWDATA[3]));
        end
    end

    // Request handshake: raise req, wait for ack or timeout, then drain guard
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    if (ack || (r_cnt == c_TO_LAST)) begin
                        r_state <= S_GUARD;
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_GUARD: begin
                    if (r_cnt == c_GUARD_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Read mux, only active during a read data phase
    always_comb begin
        w_rdata = '0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_addr)
                c_OFF_DADR:   w_rdata[ADDR_WIDTH-1:0] = r_dadr;
                c_OFF_CADR:   w_rdata[ADDR_WIDTH-1:0] = r_cadr;
                c_OFF_CFG:    w_rdata[2:0] = {r_ie, r_dbit, r_dlen};
                c_OFF_STATUS: w_rdata[3:0] = {r_err_wb, r_err_to, r_done, w_busy};
                default:      w_rdata = '0;
            endcase
        end
    end

    assign HRDATA    = w_rdata;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign req       = r_req;
    assign DADR      = r_dadr;
    assign CADR      = r_cadr;
    assign DLEN      = r_dlen;
    assign DBIT      = r_dbit;
    assign irq       = (r_done & r_ie) | r_err_to | r_err_wb;

endmodule
`default_nettype wire

// File: tb/tb_ssp_ahb_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssp_ahb_regs
//  Description : Self-checking bench for ssp_ahb_regs: register table,
//                handshake corner sequences and randomized bus traffic
//                against a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssp_ahb_regs;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int G     = 6;
    localparam int T     = 8;
    localparam int AMASK = (1 << AW) - 1;

    logic          HCLK;
    logic          HRESET;
    logic          HSEL;
    logic [7:0]    HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic          HREADY;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic          ack;
    logic          req;
    logic [AW-1:0] DADR;
    logic [AW-1:0] CADR;
    logic          DLEN;
    logic          DBIT;
    logic          irq;

    ssp_ahb_regs #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .GUARD_CYCLES  (G),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HREADY   (HREADY),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .ack      (ack),
        .req      (req),
        .DADR     (DADR),
        .CADR     (CADR),
        .DLEN     (DLEN),
        .DBIT     (DBIT),
        .irq      (irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: req age / guard countdown, plain register copies
    int m_dadr, m_cadr;
    bit m_dlen, m_dbit, m_ie, m_done, m_to, m_wb;
    bit m_req;
    int m_age, m_guard;
    bit m_dp_valid, m_dp_write;
    int m_dp_addr;

    initial begin
        m_dadr = 0; m_cadr = 0; m_dlen = 0; m_dbit = 0; m_ie = 0;
        m_done = 0; m_to = 0; m_wb = 0; m_req = 0; m_age = 0; m_guard = 0;
        m_dp_valid = 0; m_dp_write = 0; m_dp_addr = 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit busy, wr, start;
        if (HRESET) begin
            m_dadr = 0; m_cadr = 0; m_dlen = 0; m_dbit = 0; m_ie = 0;
            m_done = 0; m_to = 0; m_wb = 0; m_req = 0; m_age = 0; m_guard = 0;
            m_dp_valid = 0; m_dp_write = 0; m_dp_addr = 0;
            return;
        end
        busy  = m_req || (m_guard > 0);
        wr    = m_dp_valid && m_dp_write;
        start = wr && (m_dp_addr == 3) && HWDATA[0];
        if (wr) begin
            case (m_dp_addr)
                0: if (busy) m_wb = 1; else m_dadr = int'(HWDATA) & AMASK;
                1: if (busy) m_wb = 1; else m_cadr = int'(HWDATA) & AMASK;
                2: if (busy) m_wb = 1;
                   else begin m_dlen = HWDATA[0]; m_dbit = HWDATA[1]; m_ie = HWDATA[2]; end
                3: if (start && busy) m_wb = 1;
                4: begin
                    if (HWDATA[1]) m_done = 0;
                    if (HWDATA[2]) m_to = 0;
                    if (HWDATA[3]) m_wb = 0;
                end
                default: ;
            endcase
        end
        if (m_req) begin
            if (ack) begin
                m_req = 0; m_guard = G; m_done = 1;
            end else if (m_age == T) begin
                m_req = 0; m_guard = G; m_to = 1;
            end else begin
                m_age++;
            end
        end else if (m_guard > 0) begin
            m_guard--;
        end else if (start) begin
            m_req = 1; m_age = 1;
        end
        m_dp_valid = HSEL && HTRANS[1] && HREADY;
        m_dp_addr  = int'(HADDR[4:2]);
        m_dp_write = HWRITE;
    endfunction

    function automatic int m_read();
        if (!m_dp_valid || m_dp_write) return 0;
        case (m_dp_addr)
            0: return m_dadr;
            1: return m_cadr;
            2: return {m_ie, m_dbit, m_dlen};
            4: return {m_wb, m_to, m_done, (m_req || (m_guard > 0))};
            default: return 0;
        endcase
    endfunction

    task automatic check_all();
        chk("req",       req,       m_req);
        chk("DADR",      DADR,      m_dadr);
        chk("CADR",      CADR,      m_cadr);
        chk("DLEN",      DLEN,      m_dlen);
        chk("DBIT",      DBIT,      m_dbit);
        chk("irq",       irq,       (m_done & m_ie) | m_to | m_wb);
        chk("HRDATA",    HRDATA,    m_read());
        chk("HREADYOUT", HREADYOUT, 1);
        chk("HRESP",     HRESP,     0);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge HCLK);
        model_step();
        @(negedge HCLK);
        check_all();
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_idle();
        ack = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ahb_write(input logic [7:0] addr, input logic [15:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        tick();
        bus_idle();
        HWDATA = data;
        tick();
    endtask

    task automatic ahb_read(input logic [7:0] addr, output logic [15:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        tick();
        bus_idle();
        data = HRDATA;
        tick();
    endtask

    task automatic read_chk(input string name, input logic [7:0] addr, input logic [15:0] exp);
        logic [15:0] d;
        ahb_read(addr, d);
        chk(name, d, exp);
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int n;
        tbl[0]  = '{0, 8'h00, 16'h0000, 16'h0000};
        tbl[1]  = '{0, 8'h10, 16'h0000, 16'h0000};
        tbl[2]  = '{1, 8'h00, 16'h0015, 16'h0000};
        tbl[3]  = '{1, 8'h04, 16'h002A, 16'h0000};
        tbl[4]  = '{1, 8'h08, 16'h0003, 16'h0000};
        tbl[5]  = '{0, 8'h00, 16'h0000, 16'h0015};
        tbl[6]  = '{0, 8'h04, 16'h0000, 16'h002A};
        tbl[7]  = '{0, 8'h08, 16'h0000, 16'h0003};
        tbl[8]  = '{1, 8'h00, 16'hFFFF, 16'h0000};
        tbl[9]  = '{0, 8'h00, 16'h0000, 16'h003F};
        tbl[10] = '{1, 8'h08, 16'hFFFF, 16'h0000};
        tbl[11] = '{0, 8'h08, 16'h0000, 16'h0007};
        tbl[12] = '{0, 8'h0C, 16'h0000, 16'h0000};
        tbl[13] = '{0, 8'h14, 16'h0000, 16'h0000};
        tbl[14] = '{0, 8'h1C, 16'h0000, 16'h0000};
        tbl[15] = '{1, 8'h14, 16'hFFFF, 16'h0000};
        tbl[16] = '{1, 8'h00, 16'h0015, 16'h0000};
        tbl[17] = '{1, 8'h08, 16'h0003, 16'h0000};
        tbl[18] = '{0, 8'h10, 16'h0000, 16'h0000};

        HRESET = 1'b1; HSEL = 1'b0; HADDR = 8'h00; HTRANS = 2'b00;
        HWRITE = 1'b0; HREADY = 1'b1; HWDATA = '0; ack = 1'b0;
        tick();
        tick();
        HRESET = 1'b0;
        idle(1);

        // Register access table
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].wr) ahb_write(tbl[i].addr, tbl[i].data);
            else read_chk($sformatf("tbl%0d_rd", i), tbl[i].addr, tbl[i].exp);
        end

        // START, ack three cycles after req rises: req high four cycles
        ahb_write(8'h0C, 16'h0001);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (req) begin
                n++;
                chk("fields_stable", {DADR, CADR, DLEN, DBIT}, {6'h15, 6'h2A, 1'b1, 1'b1});
            end
            ack = (k == 3);
            tick();
        end
        ack = 1'b0;
        chk("req_len_ack", n, 4);
        idle(3);
        read_chk("status_done", 8'h10, 16'h0002);

        // Config write while busy is dropped and flags ERR_WB
        ahb_write(8'h0C, 16'h0001);
        ahb_write(8'h00, 16'h0007);
        read_chk("status_busy_wb", 8'h10, 16'h000B);
        chk("irq_wb", irq, 1);
        chk("dadr_kept", DADR, 6'h15);
        ack = 1'b1; tick(); ack = 1'b0;
        idle(8);
        ahb_write(8'h10, 16'h0008);
        read_chk("status_wb_clr", 8'h10, 16'h0002);
        read_chk("dadr_rd_kept", 8'h00, 16'h0015);

        // START during guard is rejected; first accepted slot after guard
        ahb_write(8'h10, 16'h000E);
        ahb_write(8'h0C, 16'h0001);
        idle(2);
        ack = 1'b1; tick(); ack = 1'b0;
        ahb_write(8'h0C, 16'h0001);
        chk("start_in_guard", req, 0);
        idle(G - 3);
        ahb_write(8'h0C, 16'h0001);
        chk("start_after_guard", req, 1);
        ack = 1'b1; tick(); ack = 1'b0;
        idle(8);
        read_chk("status_done_wb", 8'h10, 16'h000A);

        // Timeout with no ack
        ahb_write(8'h10, 16'h000E);
        ahb_write(8'h0C, 16'h0001);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (req) n++;
            tick();
        end
        chk("req_len_timeout", n, T);
        idle(8);
        read_chk("status_to", 8'h10, 16'h0004);
        chk("irq_to", irq, 1);

        // Reset in the middle of a request
        ahb_write(8'h10, 16'h000E);
        ahb_write(8'h0C, 16'h0001);
        idle(1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk("rst_req", req, 0);
        chk("rst_fields", {DADR, CADR, DLEN, DBIT, irq}, 0);
        read_chk("rst_dadr", 8'h00, 16'h0000);
        read_chk("rst_cfg", 8'h08, 16'h0000);
        read_chk("rst_status", 8'h10, 16'h0000);

        // DONE with IE raises irq; a stray ack in IDLE changes nothing
        ahb_write(8'h08, 16'h0004);
        ahb_write(8'h0C, 16'h0001);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("irq_done_ie", irq, 1);
        idle(8);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("stray_ack_req", req, 0);
        read_chk("stray_ack_status", 8'h10, 16'h0002);

        // Randomized pipelined traffic against the model
        for (int i = 0; i < 3000; i++) begin
            HSEL   = ($urandom_range(0, 9) < 8);
            HTRANS = 2'($urandom_range(0, 3));
            HWRITE = 1'($urandom_range(0, 1));
            HREADY = ($urandom_range(0, 9) != 0);
            HADDR  = 8'($urandom);
            HWDATA = 16'($urandom);
            ack    = ($urandom_range(0, 4) == 0);
            HRESET = ($urandom_range(0, 299) == 0);
            tick();
        end
        HRESET = 1'b0;
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
